// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
//
// Purpose:
//   NUM_CH independent clock dividers driven from one system clock. Each
//   channel produces a registered near-50% square wave and a one-cycle tick
//   per period. The divisor of each channel can be changed at run time. A new
//   divisor is held in a shadow register and becomes active only at a period
//   boundary, so the outputs never glitch.
//
// Parameters:
//   NUM_CH      number of channels (>= 1)
//   WIDTH       counter / divisor width in bits
//   DEFAULT_DIV divisor loaded into every channel at reset (< 2**WIDTH)
//
// Ports:
//   clk       in   1             system clock, all state on rising edge
//   rst       in   1             asynchronous active-low reset
//   en        in   1             global run enable (0 freezes all counters)
//   sync_clr  in   1             restart all channels at count 0
//   wr_en     in   1             divisor write strobe
//   wr_ch     in   CH_W          channel index for the write
//   wr_div    in   WIDTH         new divisor (0 = channel off)
//   tick      out  NUM_CH        one-cycle pulse per channel period
//   slow_clk  out  NUM_CH        divided square wave
//   pend      out  NUM_CH        shadow divisor differs from active divisor
// -----------------------------------------------------------------------------
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50000000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic [WIDTH-1:0] half_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic             wr_hit;
    logic             wrap;

    // Out-of-range wr_ch values never match any channel, so they are dropped.
    assign wr_hit = wr_en && (wr_ch == CH_W'(g));
    assign shd_d  = wr_hit ? wr_div : shd_q;

    // act_q != 0 guards the subtraction; an idle channel never wraps.
    assign wrap = (act_q != '0) && (cnt_q == (act_q - WIDTH'(1)));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      tick_d = 1'b0;
      if (sync_clr) begin
        // Phase align: a same-cycle write is already folded into shd_d.
        cnt_d = '0;
        act_d = shd_d;
      end else if (act_q == '0) begin
        // Idle: the shadow is also 0 here, so shd_d is exactly the
        // write-through value (0 when no write targets this channel).
        cnt_d = '0;
        act_d = shd_d;
      end else if (en) begin
        if (wrap) begin
          cnt_d  = '0;
          act_d  = shd_d;  // a write on the wrap edge wins directly
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end

    // Square wave from next-state values: low for ceil(D/2) counts, high for
    // floor(D/2). When frozen the next state equals the current state, so the
    // same expression also holds slow_clk steady. Idle forces it low.
    assign half_d = (act_d >> 1) + WIDTH'(act_d[0]);
    assign slow_d = (act_d != '0) && (cnt_d >= half_d);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        act_q  <= RST_DIV;
        shd_q  <= RST_DIV;
        tick_q <= 1'b0;
        slow_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        tick_q <= tick_d;
        slow_q <= slow_d;
      end
    end

    assign tick[g]     = tick_q;
    assign slow_clk[g] = slow_q;
    assign pend[g]     = (shd_q != act_q);
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Directed bench for multi_clock_divider with WIDTH=8, DEFAULT_DIV=4. NUM_CH=5
// so that the 3-bit wr_ch can carry indices beyond the last channel.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Tick/slow_clk patterns are per-edge bit strings, bit k = k-th edge of a run.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

  localparam int NUM_CH      = 5;
  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic              en       = 1'b0;
  logic              sync_clr = 1'b0;
  logic              wr_en    = 1'b0;
  logic [CH_W-1:0]   wr_ch    = '0;
  logic [WIDTH-1:0]  wr_div   = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] slow_clk;
  logic [NUM_CH-1:0] pend;

  int total = 0;
  int bad   = 0;

  multi_clock_divider #(
    .NUM_CH     (NUM_CH),
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .tick    (tick),
    .slow_clk(slow_clk),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int div);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = WIDTH'(div);
    step();
    wr_en  = 1'b0;
  endtask

  // All channels share one pattern.
  task automatic run_all(input string tag, input int n,
                         input logic [31:0] tp, input logic [31:0] sp);
    logic [NUM_CH-1:0] et, es;
    for (int k = 0; k < n; k++) begin
      step();
      et = {NUM_CH{tp[k]}};
      es = {NUM_CH{sp[k]}};
      chk($sformatf("%s tick k%0d", tag, k), 32'(tick), 32'(et));
      chk($sformatf("%s slow k%0d", tag, k), 32'(slow_clk), 32'(es));
    end
  endtask

  // Two channels checked side by side.
  task automatic run2(input string tag, input int n,
                      input int ca, input logic [31:0] ta, input logic [31:0] sa,
                      input int cb, input logic [31:0] tb, input logic [31:0] sb);
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("%s c%0d tick k%0d", tag, ca, k), 32'(tick[ca]), 32'(ta[k]));
      chk($sformatf("%s c%0d slow k%0d", tag, ca, k), 32'(slow_clk[ca]), 32'(sa[k]));
      chk($sformatf("%s c%0d tick k%0d", tag, cb, k), 32'(tick[cb]), 32'(tb[k]));
      chk($sformatf("%s c%0d slow k%0d", tag, cb, k), 32'(slow_clk[cb]), 32'(sb[k]));
    end
  endtask

  initial begin
    // Reset asserted between edges, held across two edges.
    #2 rst = 1'b0;
    step();
    step();
    chk("rst tick", 32'(tick), 0);
    chk("rst slow", 32'(slow_clk), 0);
    chk("rst pend", 32'(pend), 0);

    // Release: divisor 4 everywhere, first tick on edge 4.
    en  = 1'b1;
    rst = 1'b1;
    run_all("rel", 8, 32'b1000_1000, 32'b0110_0110);
    chk("rel pend", 32'(pend), 0);

    // ch1 -> 5 written mid-period (cnt 1 -> 2 on the write edge).
    step();
    wr(1, 5);
    chk("wr5 pend a", 32'(pend), 32'b00010);
    step();
    chk("wr5 pend b", 32'(pend), 32'b00010);
    chk("wr5 tick b", 32'(tick), 0);
    step();
    chk("wr5 wrap tick", 32'(tick), 32'b11111);
    chk("wr5 wrap slow", 32'(slow_clk), 0);
    chk("wr5 wrap pend", 32'(pend), 0);
    run2("div5", 10, 1, 32'b10_0001_0000, 32'b01_1000_1100,
                     0, 32'b00_1000_1000, 32'b10_0110_0110);

    // ch2 -> 0 at cnt 2: finishes the period, then idles.
    wr(2, 0);
    chk("off pend", 32'(pend), 32'b00100);
    chk("off tick", 32'(tick[2]), 0);
    chk("off slow", 32'(slow_clk[2]), 1);
    step();
    chk("off wrap tick", 32'(tick[2]), 1);
    chk("off wrap slow", 32'(slow_clk[2]), 0);
    chk("off wrap pend", 32'(pend), 0);
    run2("idle", 4, 2, 32'b0000, 32'b0000, 0, 32'b1000, 32'b0110);
    wr(2, 3);
    chk("load3 tick", 32'(tick[2]), 0);
    chk("load3 slow", 32'(slow_clk[2]), 0);
    chk("load3 pend", 32'(pend), 0);
    run2("div3", 6, 2, 32'b100100, 32'b010010, 1, 32'b000100, 32'b100011);

    // Freeze for 7 edges with ch0 at cnt 2.
    step();
    step();
    step();
    chk("pre frz slow", 32'(slow_clk), 32'b11001);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("frz tick k%0d", k), 32'(tick), 0);
      chk($sformatf("frz slow k%0d", k), 32'(slow_clk), 32'b11001);
    end
    en = 1'b1;
    run2("resume", 4, 0, 32'b0010, 32'b1001, 1, 32'b1000, 32'b0110);

    // ch3 -> 6, giving divisors 4/5/3/6/4, then phase-align.
    wr(3, 6);
    step();
    chk("div6 tick", 32'(tick[3]), 1);
    chk("div6 pend", 32'(pend), 0);
    step();
    step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("sclr tick", 32'(tick), 0);
    chk("sclr slow", 32'(slow_clk), 0);
    run2("sclr a", 6, 2, 32'b100100, 32'b010010, 3, 32'b100000, 32'b011100);

    // Second align with a same-cycle write of 2 to ch4.
    sync_clr = 1'b1;
    wr(4, 2);
    sync_clr = 1'b0;
    chk("sclrw tick", 32'(tick), 0);
    chk("sclrw slow", 32'(slow_clk), 0);
    chk("sclrw pend", 32'(pend), 0);
    run2("sclr b", 6, 0, 32'b001000, 32'b100110, 1, 32'b010000, 32'b001100);
    chk("sclrw c4 tick", 32'(tick[4]), 1);
    chk("sclrw c4 slow", 32'(slow_clk[4]), 0);

    // Asynchronous reset mid-period with pend and slow_clk high.
    wr(0, 7);
    chk("pre rst pend", 32'(pend), 32'b00001);
    chk("pre rst slow", 32'(slow_clk), 32'b10001);
    #3 rst = 1'b0;
    #1;
    chk("arst tick", 32'(tick), 0);
    chk("arst slow", 32'(slow_clk), 0);
    chk("arst pend", 32'(pend), 0);
    step();
    step();
    rst = 1'b1;

    // ch3 -> 1 through an align, then 2 written on a wrap edge.
    sync_clr = 1'b1;
    wr(3, 1);
    sync_clr = 1'b0;
    chk("div1 tick", 32'(tick[3]), 0);
    chk("div1 slow", 32'(slow_clk[3]), 0);
    chk("div1 pend", 32'(pend), 0);
    run2("div1", 4, 3, 32'b1111, 32'b0000, 0, 32'b1000, 32'b0110);
    wr(3, 2);
    chk("div2 tick", 32'(tick[3]), 1);
    chk("div2 slow", 32'(slow_clk[3]), 0);
    chk("div2 pend", 32'(pend), 0);
    run2("div2", 4, 3, 32'b1010, 32'b0101, 0, 32'b0100, 32'b0011);

    // Writes to non-existent channels are dropped.
    wr(5, 9);
    chk("oor5 pend", 32'(pend), 0);
    wr(7, 9);
    chk("oor7 pend", 32'(pend), 0);
    run2("oor", 4, 0, 32'b0001, 32'b1100, 3, 32'b1010, 32'b0101);

    // Shadow writes still land while frozen.
    en = 1'b0;
    wr(1, 6);
    chk("frz wr pend", 32'(pend), 32'b00010);
    chk("frz wr tick", 32'(tick), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
